// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage.
`timescale 1ns/1ps
package wb_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // One architectural result waiting to be written back.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } result_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order synchronous FIFO used to buffer load results.
// Push is ignored when full and pop is ignored when empty.
// Push and pop on the same edge are allowed.
`timescale 1ns/1ps
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: merges un-stallable ALU results with buffered load
// results into a single registered register-file write port, and tracks
// outstanding writes per register for RAW hazard detection in decode.
`timescale 1ns/1ps
module wb_commit #(
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              WriteReg,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] dataW
);

    import wb_pkg::*;

    localparam int              ENT_W   = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Load-path FIFO
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [ENT_W-1:0]  fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // Commit selection
    logic              sel_valid_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    // Output register
    logic              write_reg_r;
    logic [ADDR_W-1:0] addr_w_r;
    logic [DATA_W-1:0] data_w_r;

    // Scoreboard
    logic [CNT_W-1:0]  cnt_r   [NUM_REGS];
    logic [CNT_W-1:0]  cnt_nxt_s [NUM_REGS];
    logic              issue_fire_s;

    assign mem_ready   = !fifo_full_s;
    assign fifo_push_s = mem_valid && !fifo_full_s;
    // The ALU cannot be stalled, so the FIFO only drains on ALU-idle cycles.
    assign fifo_pop_s  = !alu_valid && !fifo_empty_s;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_load_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data ({mem_addr, mem_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Priority select: ALU result first, else the oldest buffered load.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        if (alu_valid) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = alu_addr;
            sel_data_s  = alu_data;
        end else if (!fifo_empty_s) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = fifo_head_s[ENT_W-1:DATA_W];
            sel_data_s  = fifo_head_s[DATA_W-1:0];
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Register-file write port; r0 results are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg_r <= 1'b0;
            addr_w_r    <= {ADDR_W{1'b0}};
            data_w_r    <= {DATA_W{1'b0}};
        end else begin
            write_reg_r <= sel_valid_s && (sel_addr_s != {ADDR_W{1'b0}});
            if (sel_valid_s) begin
                addr_w_r <= sel_addr_s;
                data_w_r <= sel_data_s;
            end
        end
    end

    assign WriteReg = write_reg_r;
    assign addrW    = addr_w_r;
    assign dataW    = data_w_r;

    // Headroom is judged on the current count only, ignoring a coinciding retire.
    assign issue_ready  = (cnt_r[issue_addr] != CNT_MAX);
    assign issue_fire_s = issue_valid && issue_ready && (issue_addr != {ADDR_W{1'b0}});
    assign hazard_a     = (cnt_r[rs_addr] != {CNT_W{1'b0}});
    assign hazard_b     = (cnt_r[rt_addr] != {CNT_W{1'b0}});

    // Per-register next count: +1 on issue, -1 on retire (never below 0), r0 pinned at 0.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            logic inc_v;
            logic dec_v;
            inc_v = issue_fire_s && (issue_addr == ADDR_W'(i));
            dec_v = write_reg_r && (addr_w_r == ADDR_W'(i)) && (cnt_r[i] != {CNT_W{1'b0}});
            if (inc_v && !dec_v) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (dec_v && !inc_v) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
        cnt_nxt_s[0] = {CNT_W{1'b0}};
    end

    // Scoreboard counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

endmodule
